tick_gen_multi: RTL
===================

Name: tick_gen_multi

Overview:
- Multi-channel, runtime-programmable clock-enable generator. Successor to the fixed single-output clock divider.
- Each of N_CH channels divides the system clock by a per-channel divisor. Each channel produces:
  - a one-cycle tick (clock enable), and
  - a near-50% square wave.
- Divisors are reprogrammed over a valid/ready config port. Updates are glitch-free and take effect at the period boundary.
- Feeds game-logic timers, animation rates and display scan in the system clock domain. It generates no derived clocks.

Parameters:
- N_CH, 4, number of independent channels (1..16).
- DIV_W, 27, divisor/counter width; covers 1 Hz at 100 MHz.
- DEF_DIV, 1_000_000, divisor loaded into every channel at reset (must be 1..2^DIV_W-1).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset, synchronous, active-high.
- en  in  N_CH  per-channel run enable.
- sync  in  1  restart all channel counters in phase.
- cfg_valid  in  1  config request.
- cfg_ch  in  4  target channel index.
- cfg_div  in  DIV_W  new divisor.
- cfg_ready  out  1  config may be accepted this cycle.
- cfg_err  out  1  one-cycle pulse: accepted request rejected.
- tick  out  N_CH  registered one-cycle pulse per period.
- sq  out  N_CH  registered square wave.

Behaviour:
- Reset (rst=1 at an edge):
  - count=0, div=DEF_DIV, pending=0, tick=0, sq=0, cfg_err=0 on all channels.
  - rst overrides all other inputs.
- Counting, channel c enabled:
  - count steps 0..div-1 and wraps to 0.
  - tick[c] <= (count==div-1), so tick is high exactly once every div cycles.
  - First tick appears after the div-th edge following reset release with en[c]=1.
- Square wave: sq[c] <= (count_next < ceil(div/2)).
  - Odd div gives a high phase one cycle longer than the low phase.
  - div=1 gives sq=1 constantly and tick=1 every cycle.
- en[c]=0: count and sq hold; tick[c]=0.
- sync=1:
  - Every count <= 0, tick <= 0.
  - Any pending divisor is applied immediately.
  - sync takes priority over en and wrap.
- cfg_ready = ~pending[cfg_ch]. It is combinational from cfg_ch. Out-of-range cfg_ch gives ready=1.
- Handshake: a request is accepted when cfg_valid && cfg_ready at an edge.
  - Accepted with cfg_div==0 or cfg_ch>=N_CH: no state change; cfg_err=1 for the next cycle only.
  - Accepted and valid, channel enabled: shadow <= cfg_div, pending <= 1.
    - At that channel's next wrap (count==div-1), div <= shadow, pending <= 0, count <= 0.
    - The tick at that wrap still belongs to the old period.
  - Accepted and valid, channel disabled, or sync in the same cycle: div <= cfg_div immediately, count <= 0, pending stays 0.
- Divisor changes never truncate or extend a period already in progress, except through sync or the disabled-channel case.
- Counter compare uses full DIV_W width. No overflow is possible because count < div ≤ 2^DIV_W-1.
- Reset mid-period or with a pending update: the pending update is discarded and div returns to DEF_DIV.

Decomposition:
- Package tick_gen_pkg:
  - clog2 function.
  - CH_IDX_W constant.
  - DIV_MIN=1 constant.
- Sub-module tick_gen_ch, one per channel via generate. It holds count, div, shadow, pending and the tick/sq registers. Its inputs are en, sync, load_now, load_shadow and new_div.
- The top level does request decode, validity check, the cfg_ready mux and cfg_err.

Test Plan:
1. DEF_DIV=4; release rst, en=0001 -> tick[0] high after edges 4, 8, 12; sq[0] after edges 1..8 = 1,0,0,1,1,0,0,1; tick[3:1]=0.
2. Ch0 running at div=4 with count=1; write div=6 -> cfg_ready low for ch0 until the edge-4 wrap; next ticks at edges 10, 16; a second write during pending is stalled.
3. Write div=1 to enabled ch1 -> after wrap, tick[1]=1 every cycle and sq[1]=1 constant; write div=5 -> sq high 3 of 5 cycles.
4. Write div=0 to ch2, then cfg_ch=9 -> each gives a one-cycle cfg_err pulse; ch2 period stays 4; no pending flag set.
5. Channels at count 0,1,2,3 with div=4; pulse sync -> all counts 0; all four ticks coincide 4 edges later; same-cycle write to ch3 takes effect immediately.
6. Assert rst with pending=1 and tick high -> next edge all outputs 0, divisors 4, cfg_ready=1.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the multi-channel tick generator.
// Request decode in the top level and every channel import this package.
package tick_gen_pkg;

   localparam int CH_IDX_W = 4;
   localparam int DIV_MIN  = 1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// One divider channel: period counter, active and shadow divisors, and the
// registered tick pulse and square-wave outputs.
module tick_gen_ch
   import tick_gen_pkg::*;
#(
   parameter int DIV_W   = 27,
   parameter int DEF_DIV = 1_000_000
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             load_now,
   input  logic             load_shadow,
   input  logic [DIV_W-1:0] new_div,
   output logic             tick,
   output logic             sq,
   output logic             pending
);

   logic [DIV_W-1:0] count;
   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] shadow;
   logic [DIV_W-1:0] count_nx;
   logic [DIV_W-1:0] div_nx;
   logic [DIV_W-1:0] shadow_nx;
   logic             pending_nx;
   logic             tick_nx;
   logic             sq_nx;
   logic             wrap;
   logic [DIV_W:0]   half;

   // A restart (sync or an immediate load) wins over the normal period wrap;
   // a queued divisor only becomes active at a restart or at a wrap.
   always_comb begin
      count_nx   = count;
      div_nx     = div;
      shadow_nx  = shadow;
      pending_nx = pending;
      tick_nx    = 1'b0;
      half       = '0;
      wrap       = en && (count == (div - DIV_W'(1)));

      if (sync || load_now) begin
         count_nx   = '0;
         pending_nx = 1'b0;
         if (load_now) begin
            div_nx = new_div;
         end else if (pending) begin
            div_nx = shadow;
         end
      end else if (wrap) begin
         tick_nx  = 1'b1;
         count_nx = '0;
         if (pending) begin
            div_nx     = shadow;
            pending_nx = 1'b0;
         end
      end else if (en) begin
         count_nx = count + DIV_W'(1);
      end

      if (load_shadow) begin
         shadow_nx  = new_div;
         pending_nx = 1'b1;
      end

      // ceil(div/2) computed one bit wider so the largest divisor cannot overflow
      half  = ({1'b0, div_nx} + (DIV_W + 1)'(1)) >> 1;
      sq_nx = (en || sync) ? ({1'b0, count_nx} < half) : sq;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         div     <= DIV_W'(DEF_DIV);
         shadow  <= DIV_W'(DEF_DIV);
         pending <= 1'b0;
         tick    <= 1'b0;
         sq      <= 1'b0;
      end else begin
         count   <= count_nx;
         div     <= div_nx;
         shadow  <= shadow_nx;
         pending <= pending_nx;
         tick    <= tick_nx;
         sq      <= sq_nx;
      end
   end

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable clock-enable generator: decodes divisor writes,
// rejects bad requests with a one-cycle error pulse and drives N_CH channels.
module tick_gen_multi
   import tick_gen_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int DIV_W   = 27,
   parameter int DEF_DIV = 1_000_000
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic [N_CH-1:0]     en,
   input  logic                sync,
   input  logic                cfg_valid,
   input  logic [CH_IDX_W-1:0] cfg_ch,
   input  logic [DIV_W-1:0]    cfg_div,
   output logic                cfg_ready,
   output logic                cfg_err,
   output logic [N_CH-1:0]     tick,
   output logic [N_CH-1:0]     sq
);

   logic [N_CH-1:0] pending;
   logic [N_CH-1:0] load_now;
   logic [N_CH-1:0] load_shadow;
   logic            ch_ok;
   logic            div_ok;
   logic            accept;
   logic            req_ok;

   assign ch_ok  = {1'b0, cfg_ch} < (CH_IDX_W + 1)'(N_CH);
   assign div_ok = cfg_div >= DIV_W'(DIV_MIN);
   assign accept = cfg_valid && cfg_ready;
   assign req_ok = accept && ch_ok && div_ok;

   // Out-of-range channels never match, so they report ready and get rejected.
   always_comb begin
      cfg_ready = 1'b1;
      for (int c = 0; c < N_CH; c++) begin
         if (cfg_ch == CH_IDX_W'(c)) begin
            cfg_ready = ~pending[c];
         end
      end
   end

   // Running channels queue the divisor for their next wrap; idle channels,
   // or any channel during sync, take it immediately.
   always_comb begin
      load_now    = '0;
      load_shadow = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (req_ok && (cfg_ch == CH_IDX_W'(c))) begin
            load_now[c]    = !en[c] || sync;
            load_shadow[c] = en[c] && !sync;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= accept && !(ch_ok && div_ok);
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      tick_gen_ch #(
         .DIV_W   (DIV_W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .en          (en[g]),
         .sync        (sync),
         .load_now    (load_now[g]),
         .load_shadow (load_shadow[g]),
         .new_div     (cfg_div),
         .tick        (tick[g]),
         .sq          (sq[g]),
         .pending     (pending[g])
      );
   end

endmodule
